sata_cmd_arbiter: RTL and testbench

- Shares the single command interface of sata_stack between two requesters, port 0 and port 1.
- Arbitrates round-robin, latches the winner's command fields and drives write_data_en or read_data_en.
- Tracks busy through to completion, then returns a done/error indication to the winner.
- grant also tells the top level which requester currently owns the user_din/user_dout FIFO path.

---
 rtl/sata_cmd_arbiter.sv | 228 ++++++++++++++++++++++
 tb/tb_sata_cmd_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sata_cmd_arbiter.sv
// Round-robin arbiter sharing the sata_stack command interface between two requesters.
// Optional watchdog with soft reset is enabled by defining SATA_ARB_TIMEOUT_EN.
module sata_cmd_arbiter #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000,
  parameter int          TW             = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sata_ready,
  input  logic        busy,
  input  logic [7:0]  d2h_status,
  input  logic [7:0]  d2h_error,
  output logic        write_data_en,
  output logic        read_data_en,
  output logic        single_rdwr,
  output logic [15:0] sector_count,
  output logic [47:0] sector_address,
  output logic        soft_reset_en,
  input  logic        p0_req,
  input  logic        p0_write,
  input  logic [15:0] p0_count,
  input  logic [47:0] p0_addr,
  input  logic        p1_req,
  input  logic        p1_write,
  input  logic [15:0] p1_count,
  input  logic [47:0] p1_addr,
  output logic        p0_grant,
  output logic        p0_done,
  output logic        p0_err,
  output logic        p1_grant,
  output logic        p1_done,
  output logic        p1_err,
  output logic [7:0]  err_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_READY,
    S_ISSUE,
    S_WAIT_DONE,
    S_COMPLETE
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  grant_reg, grant_next;
  logic        last_grant_reg, last_grant_next;
  logic        write_reg, write_next;
  logic [15:0] count_reg, count_next;
  logic [47:0] addr_reg, addr_next;
  logic        wr_en_reg, wr_en_next;
  logic        rd_en_reg, rd_en_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;
  logic [7:0]  err_code_reg, err_code_next;

  logic [1:0]  req;
  logic [1:0]  write_in;
  logic [15:0] count_in [2];
  logic [47:0] addr_in [2];
  logic        winner;
  logic [1:0]  port_done;
  logic [1:0]  port_err;

  assign req         = {p1_req, p0_req};
  assign write_in    = {p1_write, p0_write};
  assign count_in[0] = p0_count;
  assign count_in[1] = p1_count;
  assign addr_in[0]  = p0_addr;
  assign addr_in[1]  = p1_addr;

  // On a tie the port that was not served last wins; otherwise the lone requester.
  assign winner = (req == 2'b11) ? ~last_grant_reg : req[1];

  // Only the ERR bit of the status register is meaningful here.
  logic unused_d2h_status;
  assign unused_d2h_status = ^d2h_status[7:1];

`ifdef SATA_ARB_TIMEOUT_EN
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 24'd1);
  logic [TW-1:0] cnt_reg, cnt_next;
  logic          srst_reg, srst_next;
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT_CYCLES, 32'(TW)};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      grant_reg      <= 2'b00;
      last_grant_reg <= 1'b1;
      write_reg      <= 1'b0;
      count_reg      <= 16'd0;
      addr_reg       <= 48'd0;
      wr_en_reg      <= 1'b0;
      rd_en_reg      <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      err_code_reg   <= 8'd0;
`ifdef SATA_ARB_TIMEOUT_EN
      cnt_reg        <= '0;
      srst_reg       <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      write_reg      <= write_next;
      count_reg      <= count_next;
      addr_reg       <= addr_next;
      wr_en_reg      <= wr_en_next;
      rd_en_reg      <= rd_en_next;
      done_reg       <= done_next;
      err_reg        <= err_next;
      err_code_reg   <= err_code_next;
`ifdef SATA_ARB_TIMEOUT_EN
      cnt_reg        <= cnt_next;
      srst_reg       <= srst_next;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    write_next      = write_reg;
    count_next      = count_reg;
    addr_next       = addr_reg;
    wr_en_next      = wr_en_reg;
    rd_en_next      = rd_en_reg;
    done_next       = 1'b0;
    err_next        = 1'b0;
    err_code_next   = err_code_reg;
`ifdef SATA_ARB_TIMEOUT_EN
    cnt_next        = cnt_reg;
    srst_next       = 1'b0;
`endif

    case (state_reg)
      S_IDLE: begin
        if (|req) begin
          grant_next      = winner ? 2'b10 : 2'b01;
          last_grant_next = winner;
          write_next      = write_in[winner];
          count_next      = count_in[winner];
          addr_next       = addr_in[winner];
          state_next      = S_WAIT_READY;
        end
      end
      S_WAIT_READY: begin
        if (sata_ready && !busy) begin
          wr_en_next = write_reg;
          rd_en_next = ~write_reg;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Enable stays up until the stack acknowledges by raising busy.
        if (busy) begin
          wr_en_next = 1'b0;
          rd_en_next = 1'b0;
          state_next = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (!busy) begin
          done_next     = 1'b1;
          err_next      = d2h_status[0];
          err_code_next = d2h_error;
          state_next    = S_COMPLETE;
        end
      end
      S_COMPLETE: begin
        grant_next = 2'b00;
        state_next = S_IDLE;
      end
      default: begin
        grant_next = 2'b00;
        wr_en_next = 1'b0;
        rd_en_next = 1'b0;
        state_next = S_IDLE;
      end
    endcase

`ifdef SATA_ARB_TIMEOUT_EN
    if (state_reg == S_WAIT_READY || state_reg == S_ISSUE || state_reg == S_WAIT_DONE) begin
      cnt_next = cnt_reg + {{(TW-1){1'b0}}, 1'b1};
      // Watchdog overrides whatever the command phase wanted this cycle.
      if (cnt_reg == TIMEOUT_LAST) begin
        wr_en_next    = 1'b0;
        rd_en_next    = 1'b0;
        srst_next     = 1'b1;
        done_next     = 1'b1;
        err_next      = 1'b1;
        err_code_next = 8'hFF;
        state_next    = S_COMPLETE;
      end
    end else if (state_next == S_WAIT_READY) begin
      cnt_next = '0;
    end
`endif
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign port_done[gi] = done_reg & grant_reg[gi];
    assign port_err[gi]  = err_reg & grant_reg[gi];
  end

  assign p0_grant       = grant_reg[0];
  assign p1_grant       = grant_reg[1];
  assign p0_done        = port_done[0];
  assign p1_done        = port_done[1];
  assign p0_err         = port_err[0];
  assign p1_err         = port_err[1];
  assign err_code       = err_code_reg;
  assign write_data_en  = wr_en_reg;
  assign read_data_en   = rd_en_reg;
  assign single_rdwr    = 1'b0;
  assign sector_count   = count_reg;
  assign sector_address = addr_reg;
`ifdef SATA_ARB_TIMEOUT_EN
  assign soft_reset_en  = srst_reg;
`else
  assign soft_reset_en  = 1'b0;
`endif

endmodule

// File: tb/tb_sata_cmd_arbiter.sv
// Testbench for sata_cmd_arbiter: directed and random commands against a transaction-level model.
// The watchdog scenario is exercised only when SATA_ARB_TIMEOUT_EN is defined.
module tb_sata_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sata_ready, busy;
  logic [7:0]  d2h_status, d2h_error;
  logic        write_data_en, read_data_en, single_rdwr, soft_reset_en;
  logic [15:0] sector_count;
  logic [47:0] sector_address;
  logic        p0_req, p0_write, p1_req, p1_write;
  logic [15:0] p0_count, p1_count;
  logic [47:0] p0_addr, p1_addr;
  logic        p0_grant, p0_done, p0_err, p1_grant, p1_done, p1_err;
  logic [7:0]  err_code;

  always #5 clk = ~clk;

  sata_cmd_arbiter #(.TIMEOUT_CYCLES(24'd100), .TW(24)) dut (
    .clk(clk), .rst_n(rst_n), .sata_ready(sata_ready), .busy(busy),
    .d2h_status(d2h_status), .d2h_error(d2h_error),
    .write_data_en(write_data_en), .read_data_en(read_data_en),
    .single_rdwr(single_rdwr), .sector_count(sector_count),
    .sector_address(sector_address), .soft_reset_en(soft_reset_en),
    .p0_req(p0_req), .p0_write(p0_write), .p0_count(p0_count), .p0_addr(p0_addr),
    .p1_req(p1_req), .p1_write(p1_write), .p1_count(p1_count), .p1_addr(p1_addr),
    .p0_grant(p0_grant), .p0_done(p0_done), .p0_err(p0_err),
    .p1_grant(p1_grant), .p1_done(p1_done), .p1_err(p1_err),
    .err_code(err_code)
  );

  int compared = 0;
  int mismatched = 0;
  bit srst_exp = 1'b0;
  int last_w = 1;      // model: port served most recently (1 after reset)
  int win_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and check the always-true properties.
  task automatic tick();
    @(negedge clk);
    chk("grant_not_both", 64'(p0_grant & p1_grant), 64'd0);
    chk("single_rdwr", 64'(single_rdwr), 64'd0);
    chk("soft_reset_en", 64'(soft_reset_en), 64'(srst_exp));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, {p0_grant, p1_grant, p0_done, p1_done, p0_err, p1_err,
                         write_data_en, read_data_en, soft_reset_en, single_rdwr}, 64'd0);
    chk({tag, "_count"}, 64'(sector_count), 64'd0);
    chk({tag, "_addr"}, 64'(sector_address), 64'd0);
    chk({tag, "_err_code"}, 64'(err_code), 64'd0);
  endtask

  task automatic run_cmd(input bit r0, input bit r1,
                         input bit w0, input logic [15:0] c0, input logic [47:0] a0,
                         input bit w1, input logic [15:0] c1, input logic [47:0] a1,
                         input logic [7:0] st, input logic [7:0] er,
                         input int hold, input int pre, input int blen, input bit glitch);
    int win;
    bit ew;
    logic [15:0] ec;
    logic [47:0] ea;
    win = (r0 && r1) ? ((last_w == 0) ? 1 : 0) : (r0 ? 0 : 1);
    ew  = (win == 1) ? w1 : w0;
    ec  = (win == 1) ? c1 : c0;
    ea  = (win == 1) ? a1 : a0;
    p0_req = r0; p0_write = w0; p0_count = c0; p0_addr = a0;
    p1_req = r1; p1_write = w1; p1_count = c1; p1_addr = a1;
    sata_ready = 1'b0; busy = 1'b0;
    tick();
    chk("grant_p0", 64'(p0_grant), 64'(win == 0));
    chk("grant_p1", 64'(p1_grant), 64'(win == 1));
    chk("sector_count", 64'(sector_count), 64'(ec));
    chk("sector_address", 64'(sector_address), 64'(ea));
    chk("en_before_ready", 64'({write_data_en, read_data_en}), 64'd0);
    last_w = win;
    win_log.push_back(win);
    // Latched fields must ignore later changes on the request side.
    p0_write = 1'($urandom); p0_count = 16'($urandom); p0_addr = 48'({$urandom, $urandom});
    p1_write = 1'($urandom); p1_count = 16'($urandom); p1_addr = 48'({$urandom, $urandom});
    if (glitch) begin
      if (win == 0) p1_req = 1'b1; else p0_req = 1'b1;
    end
    repeat (hold) begin
      tick();
      chk("en_held_off", 64'({write_data_en, read_data_en}), 64'd0);
    end
    sata_ready = 1'b1; busy = 1'b1;
    tick();
    chk("en_while_busy", 64'({write_data_en, read_data_en}), 64'd0);
    busy = 1'b0;
    tick();
    chk("issue_wr_en", 64'(write_data_en), 64'(ew));
    chk("issue_rd_en", 64'(read_data_en), 64'(!ew));
    repeat (pre) begin
      tick();
      chk("hold_wr_en", 64'(write_data_en), 64'(ew));
      chk("hold_rd_en", 64'(read_data_en), 64'(!ew));
    end
    busy = 1'b1; sata_ready = 1'b0;
    if (glitch) begin
      if (win == 0) p1_req = 1'b0; else p0_req = 1'b0;
    end
    tick();
    chk("en_after_busy", 64'({write_data_en, read_data_en}), 64'd0);
    repeat (blen) begin
      tick();
      chk("no_early_done", 64'({p0_done, p1_done}), 64'd0);
    end
    busy = 1'b0; sata_ready = 1'b1; d2h_status = st; d2h_error = er;
    tick();
    chk("done_p0", 64'(p0_done), 64'(win == 0));
    chk("done_p1", 64'(p1_done), 64'(win == 1));
    chk("err_p0", 64'(p0_err), 64'(win == 0 && st[0]));
    chk("err_p1", 64'(p1_err), 64'(win == 1 && st[0]));
    chk("err_code", 64'(err_code), 64'(er));
    chk("grant_at_done", 64'({p1_grant, p0_grant}), (win == 1) ? 64'd2 : 64'd1);
    tick();
    chk("grant_drop", 64'({p0_grant, p1_grant}), 64'd0);
    chk("done_one_cycle", 64'({p0_done, p1_done, p0_err, p1_err}), 64'd0);
  endtask

  task automatic rand_cmd(input bit r0, input bit r1, input int hold, input bit glitch);
    run_cmd(r0, r1,
            1'($urandom), 16'($urandom), 48'({$urandom, $urandom}),
            1'($urandom), 16'($urandom), 48'({$urandom, $urandom}),
            8'($urandom), 8'($urandom),
            hold, $urandom_range(0, 3), $urandom_range(0, 6), glitch);
  endtask

  initial begin
    rst_n = 1'b0; sata_ready = 1'b0; busy = 1'b0; d2h_status = 8'h00; d2h_error = 8'h00;
    p0_req = 1'b0; p0_write = 1'b0; p0_count = 16'd0; p0_addr = 48'd0;
    p1_req = 1'b0; p1_write = 1'b0; p1_count = 16'd0; p1_addr = 48'd0;
    repeat (2) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();
    chk_all_zero("post_reset");

    // Single write on port 0, busy for about 50 cycles.
    run_cmd(1, 0, 1, 16'd8, 48'h100, 0, 16'd3, 48'h777, 8'h50, 8'h00, 0, 1, 49, 0);
    // Single read on port 1 ending in error.
    run_cmd(0, 1, 1, 16'd5, 48'h200, 0, 16'd4, 48'h300, 8'h51, 8'h04, 0, 0, 5, 0);

    // Both held together: strict alternation starting from port 0.
    win_log.delete();
    repeat (4) rand_cmd(1, 1, 1, 0);
    for (int i = 0; i < 4; i++) chk("rr_order", 64'(win_log[i]), 64'(i % 2));

    // Held off by sata_ready for 20 cycles; zero sector count passes through.
    run_cmd(1, 0, 0, 16'd0, 48'hABCD_0000_1234, 1, 16'd9, 48'h1, 8'h50, 8'h00, 20, 2, 3, 0);

    // A request raised and dropped during another command is never granted.
    rand_cmd(1, 0, 2, 1);
    p0_req = 1'b0; p1_req = 1'b0;
    repeat (3) begin
      tick();
      chk("no_ghost_grant", 64'({p0_grant, p1_grant}), 64'd0);
    end

    for (int n = 0; n < 30; n++) begin
      int pat;
      pat = $urandom_range(1, 3);
      rand_cmd(pat[0], pat[1], $urandom_range(0, 4), 0);
    end

    // Asynchronous reset during WAIT_DONE.
    p0_req = 1'b1; p1_req = 1'b1; p0_write = 1'b1; p0_count = 16'd7; p0_addr = 48'h55;
    p1_write = 1'b1; p1_count = 16'd6; p1_addr = 48'h66; sata_ready = 1'b0; busy = 1'b0;
    tick();
    sata_ready = 1'b1;
    tick();
    busy = 1'b1; sata_ready = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    tick();
    chk_all_zero("in_reset");
    rst_n = 1'b1; busy = 1'b0;
    last_w = 1;
    win_log.delete();
    rand_cmd(1, 1, 0, 0);
    chk("tie_after_reset", 64'(win_log[0]), 64'd0);

`ifdef SATA_ARB_TIMEOUT_EN
    // Busy never rises: watchdog fires 100 cycles after the grant.
    p0_req = 1'b1; p1_req = 1'b0; p0_write = 1'b1; sata_ready = 1'b0; busy = 1'b0;
    tick();
    chk("to_grant", 64'(p0_grant), 64'd1);
    last_w = 0;
    sata_ready = 1'b1;
    repeat (99) begin
      tick();
      chk("to_no_done", 64'(p0_done), 64'd0);
    end
    srst_exp = 1'b1;
    tick();
    srst_exp = 1'b0;
    chk("to_done", 64'(p0_done), 64'd1);
    chk("to_err", 64'(p0_err), 64'd1);
    chk("to_err_code", 64'(err_code), 64'hFF);
    chk("to_en_drop", 64'({write_data_en, read_data_en}), 64'd0);
    tick();
    chk("to_grant_drop", 64'(p0_grant), 64'd0);
    rand_cmd(1, 1, 0, 0);
`endif

    p0_req = 1'b0; p1_req = 1'b0;
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
